// File: rtl/avst_header_inserter_pkg.sv
// Shared types and helpers for the Avalon-ST header insert/strip stage.
package avst_hdr_pkg;

    // Encoding of the insert/strip controller.
    typedef enum logic [1:0] {
        IDLE_ST  = 2'd0,
        HDR_ST   = 2'd1,
        STRIP_ST = 2'd2,
        DATA_ST  = 2'd3
    } hdr_st_t;

    // Operating mode, captured at start of packet.
    typedef enum logic {
        HDR_INSERT = 1'b0,
        HDR_STRIP  = 1'b1
    } hdr_mode_t;

    // Bit offset of header beat idx inside the packed header vector.
    // Beat 0 occupies the most significant slice.
    function automatic int beat_lsb(input int idx, input int n_beats, input int width);
        return (n_beats - 1 - idx) * width;
    endfunction

endpackage

// File: rtl/avst_header_inserter_if.sv
// Avalon-ST streaming bundle with source (master) and sink (slave) views.
interface avalon_st_if #(
    parameter int DATA_WIDTH  = 128,
    parameter int EMPTY_WIDTH = $clog2(DATA_WIDTH / 8)
);
    logic                   valid;
    logic                   ready;
    logic                   sop;
    logic                   eop;
    logic [DATA_WIDTH-1:0]  data;
    logic [EMPTY_WIDTH-1:0] empty;

    modport master (output valid, data, sop, eop, empty, input ready);
    modport slave  (input valid, data, sop, eop, empty, output ready);
endinterface

// File: rtl/avst_header_inserter_hdr_beat_sel.sv
// Selects one DATA_WIDTH beat out of the latched header vector, beat 0 first.
module hdr_beat_sel
    import avst_hdr_pkg::*;
#(
    parameter int DATA_WIDTH    = 128,
    parameter int MAX_HDR_BEATS = 4,
    parameter int CW            = $clog2(MAX_HDR_BEATS + 1)
) (
    input  logic [MAX_HDR_BEATS*DATA_WIDTH-1:0] hdr_vec,
    input  logic [CW-1:0]                       idx,
    output logic [DATA_WIDTH-1:0]               beat
);

    // One-hot style mux over the fixed slices; out-of-range index yields zero.
    always_comb begin
        beat = '0;
        for (int i = 0; i < MAX_HDR_BEATS; i++) begin
            if (idx == CW'(i)) begin
                beat = hdr_vec[beat_lsb(i, MAX_HDR_BEATS, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/avst_header_inserter.sv
// Avalon-ST header insert/strip stage with runtime header length.
// The sop beat is only observed in IDLE; it is consumed later by HDR/STRIP/DATA.
module avst_header_inserter
    import avst_hdr_pkg::*;
#(
    parameter int DATA_WIDTH    = 128,
    parameter int MAX_HDR_BEATS = 4,
    parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    avalon_st_if.slave                            data_in,
    avalon_st_if.master                           data_out,
    input  logic [MAX_HDR_BEATS*DATA_WIDTH-1:0]   hdr_data,
    input  logic [$clog2(MAX_HDR_BEATS+1)-1:0]    hdr_beats,
    input  logic                                  mode,
    output logic                                  err_sop,
    output logic                                  err_runt
);

    localparam int CW = $clog2(MAX_HDR_BEATS + 1);
    localparam logic [CW-1:0] MAX_B = CW'(MAX_HDR_BEATS);
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [EMPTY_WIDTH-1:0] NO_EMPTY = '0;

    localparam logic [1:0] S_IDLE  = IDLE_ST;
    localparam logic [1:0] S_HDR   = HDR_ST;
    localparam logic [1:0] S_STRIP = STRIP_ST;
    localparam logic [1:0] S_DATA  = DATA_ST;

    logic [1:0]                           state;
    logic [CW-1:0]                        cnt;
    logic [CW-1:0]                        beats_q;
    hdr_mode_t                            mode_q;
    logic [MAX_HDR_BEATS*DATA_WIDTH-1:0]  hdr_q;
    logic                                 first_q;
    logic [CW-1:0]                        beats_clamped;
    logic [DATA_WIDTH-1:0]                hdr_beat;

    assign beats_clamped = (hdr_beats > MAX_B) ? MAX_B : hdr_beats;

    hdr_beat_sel #(
        .DATA_WIDTH    (DATA_WIDTH),
        .MAX_HDR_BEATS (MAX_HDR_BEATS),
        .CW            (CW)
    ) u_beat_sel (
        .hdr_vec (hdr_q),
        .idx     (cnt),
        .beat    (hdr_beat)
    );

    // Controller state, header counter, per-packet config latch and error pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            beats_q  <= '0;
            mode_q   <= HDR_INSERT;
            hdr_q    <= '0;
            first_q  <= 1'b0;
            err_sop  <= 1'b0;
            err_runt <= 1'b0;
        end else begin
            err_sop  <= 1'b0;
            err_runt <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (data_in.valid) begin
                        if (!data_in.sop) begin
                            err_sop <= 1'b1;
                        end else begin
                            hdr_q   <= hdr_data;
                            beats_q <= beats_clamped;
                            mode_q  <= hdr_mode_t'(mode);
                            cnt     <= '0;
                            first_q <= 1'b1;
                            if (beats_clamped == '0) begin
                                state <= S_DATA;
                            end else if (mode) begin
                                state <= S_STRIP;
                            end else begin
                                state <= S_HDR;
                            end
                        end
                    end
                end
                S_HDR: begin
                    if (data_out.ready) begin
                        if (cnt == beats_q - ONE) begin
                            state <= S_DATA;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                end
                S_STRIP: begin
                    if (data_in.valid) begin
                        if (data_in.eop) begin
                            err_runt <= 1'b1;
                            state    <= S_IDLE;
                            cnt      <= '0;
                        end else if (cnt == beats_q - ONE) begin
                            state <= S_DATA;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                end
                S_DATA: begin
                    if (data_in.valid && data_out.ready) begin
                        first_q <= 1'b0;
                        if (data_in.eop) begin
                            state <= S_IDLE;
                            cnt   <= '0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Output stream and input ready, purely from state so data phase has no latency.
    always_comb begin
        data_out.valid = 1'b0;
        data_out.data  = '0;
        data_out.sop   = 1'b0;
        data_out.eop   = 1'b0;
        data_out.empty = NO_EMPTY;
        data_in.ready  = 1'b0;
        case (state)
            S_IDLE: begin
                data_in.ready = data_in.valid & ~data_in.sop;
            end
            S_HDR: begin
                data_out.valid = 1'b1;
                data_out.data  = hdr_beat;
                data_out.sop   = (cnt == '0);
            end
            S_STRIP: begin
                data_in.ready = 1'b1;
            end
            S_DATA: begin
                data_out.valid = data_in.valid;
                data_in.ready  = data_out.ready;
                data_out.data  = data_in.data;
                data_out.eop   = data_in.eop;
                data_out.empty = data_in.eop ? data_in.empty : NO_EMPTY;
                data_out.sop   = first_q & ((mode_q == HDR_STRIP) | (beats_q == '0));
            end
            default: begin
                data_in.ready = 1'b0;
            end
        endcase
    end

endmodule
